id_ex_stage: RTL and testbench

ID/EX pipeline register for the 5-stage MIPS pipeline, with load-use hazard detection and branch flush built in. It captures decoded operands, immediate, register numbers and control from ID and presents them to EX. Its `EX_rs`, `EX_rt`, `EX_rd` and `EX_RegWrite` outputs feed the forwarding unit and the EX/MEM register. A single-cycle bubble is inserted on load-use hazards, and a stall-cycle performance counter is kept.

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/id_ex_stage_load_use_detect.sv | 17 +
 rtl/id_ex_stage.sv | 134 +++++++++++++
 tb/tb_id_ex_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: control bundle,
// ALU operation classes, the architectural zero register and the bubble.
package pipeline_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,  // loads/stores: address add
    ALU_SUB   = 2'b01,  // branches: compare by subtract
    ALU_RTYPE = 2'b10,  // R-type: funct field selects the operation
    ALU_IMM   = 2'b11   // immediate arithmetic/logic
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    reg_dst;
    alu_op_e alu_op;
  } ctrl_t;

  // A bubble is an instruction with every control bit cleared: it writes
  // nothing, touches no memory and never looks like a forwarding source.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: the load in EX produces a register that the
// instruction in ID reads, so the value is not available in time even with
// forwarding. Loads into $0 never stall since $0 is hard-wired to zero.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       hazard
);

  assign hazard = ex_mem_read && (ex_rt != REG_ZERO) &&
                  ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with built-in load-use bubble insertion, branch
// flush and a free-running (wrapping) count of inserted stall bubbles.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Flush,
  input  logic [4:0]           ID_rs,
  input  logic [4:0]           ID_rt,
  input  logic [4:0]           ID_rd,
  input  logic                 ID_RegWrite,
  input  logic                 ID_MemRead,
  input  logic                 ID_MemWrite,
  input  logic                 ID_MemtoReg,
  input  logic                 ID_ALUSrc,
  input  logic                 ID_RegDst,
  input  logic [1:0]           ID_ALUOp,
  input  logic [WIDTH-1:0]     ID_ReadData1,
  input  logic [WIDTH-1:0]     ID_ReadData2,
  input  logic [WIDTH-1:0]     ID_Imm,
  input  logic [WIDTH-1:0]     ID_PC4,
  output logic [4:0]           EX_rs,
  output logic [4:0]           EX_rt,
  output logic [4:0]           EX_rd,
  output logic                 EX_RegWrite,
  output logic                 EX_MemRead,
  output logic                 EX_MemWrite,
  output logic                 EX_MemtoReg,
  output logic                 EX_ALUSrc,
  output logic                 EX_RegDst,
  output logic [1:0]           EX_ALUOp,
  output logic [WIDTH-1:0]     EX_ReadData1,
  output logic [WIDTH-1:0]     EX_ReadData2,
  output logic [WIDTH-1:0]     EX_Imm,
  output logic [WIDTH-1:0]     EX_PC4,
  output logic                 Stall,
  output logic [CNT_WIDTH-1:0] StallCount
);

  ctrl_t                id_ctrl;
  ctrl_t                ctrl_p1;
  logic [4:0]           rs_p1, rt_p1, rd_p1;
  logic [WIDTH-1:0]     rd1_p1, rd2_p1, imm_p1, pc4_p1;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 hazard;
  logic                 bubble;

  assign id_ctrl = '{
    reg_write:  ID_RegWrite,
    mem_read:   ID_MemRead,
    mem_write:  ID_MemWrite,
    mem_to_reg: ID_MemtoReg,
    alu_src:    ID_ALUSrc,
    reg_dst:    ID_RegDst,
    alu_op:     alu_op_e'(ID_ALUOp)
  };

  load_use_detect u_detect (
    .ex_mem_read (ctrl_p1.mem_read),
    .ex_rt       (rt_p1),
    .id_rs       (ID_rs),
    .id_rt       (ID_rt),
    .hazard      (hazard)
  );

  // A taken branch squashes the ID instruction, which makes any hazard it
  // would have caused moot, so Flush masks the stall request.
  assign Stall  = hazard && !Flush;
  assign bubble = Flush || hazard;

  // ---- ID -> EX boundary ----
  // Pipeline register: bubble on flush or load-use, otherwise capture ID.
  // Register numbers are cleared too so a bubble never matches forwarding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_p1 <= CTRL_BUBBLE;
      rs_p1   <= '0;
      rt_p1   <= '0;
      rd_p1   <= '0;
      rd1_p1  <= '0;
      rd2_p1  <= '0;
      imm_p1  <= '0;
      pc4_p1  <= '0;
    end else if (bubble) begin
      ctrl_p1 <= CTRL_BUBBLE;
      rs_p1   <= '0;
      rt_p1   <= '0;
      rd_p1   <= '0;
      rd1_p1  <= '0;
      rd2_p1  <= '0;
      imm_p1  <= '0;
      pc4_p1  <= '0;
    end else begin
      ctrl_p1 <= id_ctrl;
      rs_p1   <= ID_rs;
      rt_p1   <= ID_rt;
      rd_p1   <= ID_rd;
      rd1_p1  <= ID_ReadData1;
      rd2_p1  <= ID_ReadData2;
      imm_p1  <= ID_Imm;
      pc4_p1  <= ID_PC4;
    end
  end

  // Stall-bubble counter; wraps naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (Stall) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign EX_rs        = rs_p1;
  assign EX_rt        = rt_p1;
  assign EX_rd        = rd_p1;
  assign EX_RegWrite  = ctrl_p1.reg_write;
  assign EX_MemRead   = ctrl_p1.mem_read;
  assign EX_MemWrite  = ctrl_p1.mem_write;
  assign EX_MemtoReg  = ctrl_p1.mem_to_reg;
  assign EX_ALUSrc    = ctrl_p1.alu_src;
  assign EX_RegDst    = ctrl_p1.reg_dst;
  assign EX_ALUOp     = ctrl_p1.alu_op;
  assign EX_ReadData1 = rd1_p1;
  assign EX_ReadData2 = rd2_p1;
  assign EX_Imm       = imm_p1;
  assign EX_PC4       = pc4_p1;
  assign StallCount   = cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the stimulus process predicts the stage
// contents with a simple instruction-level model and queues the prediction;
// a monitor checks Stall mid-cycle and the EX registers after each edge.
module tb_id_ex_stage;

  localparam int W  = 32;
  localparam int CW = 2;

  typedef struct packed {
    logic [4:0]   rs, rt, rd;
    logic         rw, mr, mw, m2r, as, rdst;
    logic [1:0]   aop;
    logic [W-1:0] rd1, rd2, imm, pc4;
  } instr_t;

  typedef struct {
    logic          stall;
    instr_t        ex;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic Flush;
  logic [4:0] ID_rs, ID_rt, ID_rd, EX_rs, EX_rt, EX_rd;
  logic ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst;
  logic EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_RegDst;
  logic [1:0] ID_ALUOp, EX_ALUOp;
  logic [W-1:0] ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC4;
  logic [W-1:0] EX_ReadData1, EX_ReadData2, EX_Imm, EX_PC4;
  logic Stall;
  logic [CW-1:0] StallCount;

  int total = 0;
  int bad   = 0;

  exp_t   q[$];
  instr_t model_ex;
  logic [CW-1:0] model_cnt;
  instr_t dut_ex;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .Flush(Flush),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
    .ID_ALUOp(ID_ALUOp), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Imm(ID_Imm), .ID_PC4(ID_PC4),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_MemtoReg(EX_MemtoReg), .EX_ALUSrc(EX_ALUSrc), .EX_RegDst(EX_RegDst),
    .EX_ALUOp(EX_ALUOp), .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
    .EX_Imm(EX_Imm), .EX_PC4(EX_PC4),
    .Stall(Stall), .StallCount(StallCount)
  );

  assign dut_ex = '{rs: EX_rs, rt: EX_rt, rd: EX_rd,
                    rw: EX_RegWrite, mr: EX_MemRead, mw: EX_MemWrite,
                    m2r: EX_MemtoReg, as: EX_ALUSrc, rdst: EX_RegDst, aop: EX_ALUOp,
                    rd1: EX_ReadData1, rd2: EX_ReadData2, imm: EX_Imm, pc4: EX_PC4};

  task automatic check(input string name, input logic [150:0] act, input logic [150:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic apply(input instr_t v, input logic fl);
    ID_rs = v.rs; ID_rt = v.rt; ID_rd = v.rd;
    ID_RegWrite = v.rw; ID_MemRead = v.mr; ID_MemWrite = v.mw;
    ID_MemtoReg = v.m2r; ID_ALUSrc = v.as; ID_RegDst = v.rdst; ID_ALUOp = v.aop;
    ID_ReadData1 = v.rd1; ID_ReadData2 = v.rd2; ID_Imm = v.imm; ID_PC4 = v.pc4;
    Flush = fl;
  endtask

  // Present one instruction in ID for one cycle and predict the outcome.
  task automatic drive(input instr_t v, input logic fl);
    exp_t   e;
    logic   load_use;
    @(posedge clk);
    #2;
    apply(v, fl);
    load_use = model_ex.mr && model_ex.rt != 5'd0 &&
               (model_ex.rt == v.rs || model_ex.rt == v.rt);
    e.stall = load_use && !fl;
    if (fl || load_use) e.ex = '0;
    else                e.ex = v;
    if (e.stall) model_cnt = model_cnt + 1'b1;
    e.cnt    = model_cnt;
    model_ex = e.ex;
    q.push_back(e);
  endtask

  function automatic instr_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic mr);
    instr_t v;
    v = '0;
    v.rs = rs; v.rt = rt; v.rd = rd; v.mr = mr;
    v.rw = 1'b1; v.m2r = mr; v.as = mr; v.aop = mr ? 2'b00 : 2'b10;
    v.rd1 = $urandom; v.rd2 = $urandom; v.imm = $urandom; v.pc4 = {$urandom_range(0, 4095), 2'b00};
    return v;
  endfunction

  function automatic instr_t rand_instr();
    instr_t v;
    v = '0;
    v.rs = 5'($urandom_range(0, 3)); v.rt = 5'($urandom_range(0, 3));
    v.rd = 5'($urandom_range(0, 31));
    v.rw = 1'($urandom); v.mr = 1'($urandom); v.mw = 1'($urandom);
    v.m2r = 1'($urandom); v.as = 1'($urandom); v.rdst = 1'($urandom);
    v.aop = 2'($urandom);
    v.rd1 = $urandom; v.rd2 = $urandom; v.imm = $urandom; v.pc4 = $urandom;
    return v;
  endfunction

  // Monitor: Stall is checked mid-cycle against the queued prediction for
  // the current ID contents; registers are checked just after the edge.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      if (q.size() > 0) check("stall", 151'(Stall), 151'(q[0].stall));
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        it = q.pop_front();
        check("ex_regs", dut_ex, it.ex);
        check("stall_count", 151'(StallCount), 151'(it.cnt));
      end
    end
  end

  initial begin
    instr_t lw, dep;
    model_ex  = '0;
    model_cnt = '0;
    rst = 1'b1;
    apply('0, 1'b0);
    #1;
    check("reset_ex", dut_ex, '0);
    check("reset_cnt", 151'(StallCount), '0);
    check("reset_stall", 151'(Stall), '0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Plain pass-through
    dep = mk(5'd3, 5'd4, 5'd5, 1'b0);
    dep.rd1 = 32'hDEAD_BEEF;
    drive(dep, 1'b0);
    drive(mk(5'd6, 5'd7, 5'd9, 1'b0), 1'b0);

    // Load-use: lw $8, then reader of $8 held in ID across the bubble
    lw  = mk(5'd1, 5'd8, 5'd0, 1'b1);
    dep = mk(5'd8, 5'd2, 5'd10, 1'b0);
    drive(lw, 1'b0);
    drive(dep, 1'b0);
    drive(dep, 1'b0);
    drive(mk(5'd11, 5'd12, 5'd13, 1'b0), 1'b0);

    // Load into $0 never stalls
    drive(mk(5'd1, 5'd0, 5'd0, 1'b1), 1'b0);
    drive(mk(5'd0, 5'd0, 5'd14, 1'b0), 1'b0);

    // Flush beats a simultaneous hazard
    drive(lw, 1'b0);
    drive(dep, 1'b1);
    drive(dep, 1'b0);

    // Five load-use hazards: 2-bit counter wraps
    for (int i = 0; i < 5; i++) begin
      drive(lw, 1'b0);
      drive(dep, 1'b0);
      drive(dep, 1'b0);
    end

    // Randomised traffic with frequent loads and overlapping registers
    for (int i = 0; i < 400; i++) begin
      drive(rand_instr(), ($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset mid-cycle while a load-use stall is pending
    drive(lw, 1'b0);
    drive(dep, 1'b0);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_ex", dut_ex, '0);
    check("async_reset_cnt", 151'(StallCount), '0);
    check("async_reset_stall", 151'(Stall), '0);
    q.delete();
    model_ex  = '0;
    model_cnt = '0;
    apply('0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      drive(rand_instr(), ($urandom_range(0, 7) == 0));
    end

    // Drain within a bounded number of cycles
    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", 151'(q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
